// File: rtl/dmem_uart_dump_ctrl_if.sv
// ---------------------------------------------------------------------------
// dmem_uart_dump_ctrl_if
// Bundles the two buses the dump controller sits between:
//   memory side : memAddress/memReadEn (controller -> memory),
//                 memData (combinational read data), cpuBusy (CPU owns port)
//   UART side   : txStart/txData (controller -> transmitter),
//                 txBusy (transmitter still shifting a byte)
// Modports:
//   master - the dump controller
//   slave  - the memory/CPU/UART environment around it
// ---------------------------------------------------------------------------
interface dmem_uart_dump_ctrl_if;
    logic [31:0] memAddress;
    logic        memReadEn;
    logic [31:0] memData;
    logic        cpuBusy;
    logic        txStart;
    logic [7:0]  txData;
    logic        txBusy;

    modport master (
        output memAddress, memReadEn, txStart, txData,
        input  memData, cpuBusy, txBusy
    );

    modport slave (
        input  memAddress, memReadEn, txStart, txData,
        output memData, cpuBusy, txBusy
    );
endinterface

// File: rtl/dmem_uart_dump_ctrl.sv
// ---------------------------------------------------------------------------
// dmem_uart_dump_ctrl
// Dumps a contiguous word range of data memory out of the byte-wide UART.
// Each word is read through the shared combinational read port (only when
// the CPU does not own it), split into four bytes and handed to the
// transmitter one at a time under a start/busy handshake.
// Ports:
//   clk, rst              clock, asynchronous active-high reset
//   start                 one-cycle dump request, honoured only when idle
//   abort                 stop the dump at the next edge (ignored when idle)
//   firstAddr, lastAddr   inclusive word range, latched on an accepted start;
//                         lastAddr < firstAddr wraps through the top address
//   bus (master)          memory read port + UART transmit handshake
//   busy                  controller is not idle
//   done                  one-cycle pulse after the last byte has finished
//   wordCount             words fully transmitted in the current/last dump
// ---------------------------------------------------------------------------
module dmem_uart_dump_ctrl #(
    parameter int ADDR_W    = 10,
    parameter bit LSB_FIRST = 1'b0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                abort,
    input  logic [ADDR_W-1:0]   firstAddr,
    input  logic [ADDR_W-1:0]   lastAddr,
    dmem_uart_dump_ctrl_if.master bus,
    output logic                busy,
    output logic                done,
    output logic [ADDR_W:0]     wordCount
);

    typedef enum logic [2:0] {
        IDLE,
        READ,
        SEND,
        ACK_HI,
        ACK_LO
    } state_t;

    state_t            r_state;
    logic [ADDR_W-1:0] r_curAddr;
    logic [ADDR_W-1:0] r_endAddr;
    logic [1:0]        r_byteIdx;
    logic [31:0]       r_shift;
    logic              r_ackWait;
    logic              r_busy;
    logic              r_done;
    logic [ADDR_W:0]   r_wordCount;

    logic              w_readFire;
    logic              w_sendFire;

    // The read strobe and the byte strobe must react to cpuBusy/txBusy/abort
    // in the same cycle, so they are decoded from the state register rather
    // than registered a cycle late. An abort suppresses both.
    assign w_readFire = (r_state == READ) && !bus.cpuBusy && !abort;
    assign w_sendFire = (r_state == SEND) && !bus.txBusy && !abort;

    assign bus.memAddress = 32'(r_curAddr);
    assign bus.memReadEn  = w_readFire;
    assign bus.txStart    = w_sendFire;
    // The next byte to go out always sits at one end of the shift register.
    assign bus.txData     = LSB_FIRST ? r_shift[7:0] : r_shift[31:24];

    assign busy      = r_busy;
    assign done      = r_done;
    assign wordCount = r_wordCount;

    // Dump sequencer. ACK_HI gives the transmitter two cycles to raise
    // txBusy; a transmitter that finishes faster than that never shows busy,
    // so after the second quiet cycle the byte is taken as already sent.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_curAddr   <= '0;
            r_endAddr   <= '0;
            r_byteIdx   <= '0;
            r_shift     <= '0;
            r_ackWait   <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_wordCount <= '0;
        end else begin
            r_done <= 1'b0;
            if ((r_state != IDLE) && abort) begin
                r_state <= IDLE;
                r_busy  <= 1'b0;
            end else begin
                case (r_state)
                    IDLE: begin
                        if (start) begin
                            r_curAddr   <= firstAddr;
                            r_endAddr   <= lastAddr;
                            r_wordCount <= '0;
                            r_busy      <= 1'b1;
                            r_state     <= READ;
                        end
                    end
                    READ: begin
                        if (w_readFire) begin
                            r_shift   <= bus.memData;
                            r_byteIdx <= 2'd0;
                            r_state   <= SEND;
                        end
                    end
                    SEND: begin
                        if (w_sendFire) begin
                            r_ackWait <= 1'b0;
                            r_state   <= ACK_HI;
                        end
                    end
                    ACK_HI: begin
                        if (bus.txBusy || r_ackWait) begin
                            r_state <= ACK_LO;
                        end else begin
                            r_ackWait <= 1'b1;
                        end
                    end
                    ACK_LO: begin
                        if (!bus.txBusy) begin
                            if (r_byteIdx != 2'd3) begin
                                r_byteIdx <= r_byteIdx + 2'd1;
                                r_shift   <= LSB_FIRST ? (r_shift >> 8) : (r_shift << 8);
                                r_state   <= SEND;
                            end else begin
                                r_wordCount <= r_wordCount + (ADDR_W+1)'(1);
                                if (r_curAddr == r_endAddr) begin
                                    r_state <= IDLE;
                                    r_busy  <= 1'b0;
                                    r_done  <= 1'b1;
                                end else begin
                                    // Natural overflow gives the wrap to address 0.
                                    r_curAddr <= r_curAddr + ADDR_W'(1);
                                    r_state   <= READ;
                                end
                            end
                        end
                    end
                    default: begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: doc/dmem_uart_dump_ctrl.md
Name: dmem_uart_dump_ctrl

Overview:
- Sequences a dump of a contiguous data-memory word range out over the byte-wide UART transmitter.
- Reads one 32-bit word at a time from the data memory's combinational read port, yielding to the CPU whenever the CPU owns the port.
- Serialises each word into 4 bytes and hands them to the transmitter under a start/busy handshake.
- Sits between the data memory, the CPU memory stage and the UART transmitter, replacing free-running counter-driven dumping.

Parameters:
- ADDR_W, 10, word-address width of the data memory (1024 words).
- LSB_FIRST, 0, 0 = byte[31:24] sent first; 1 = byte[7:0] sent first.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle request to begin a dump; sampled only in IDLE.
- abort  in  1  terminate the dump; checked every cycle outside IDLE.
- firstAddr  in  ADDR_W  first word address, latched on an accepted start.
- lastAddr  in  ADDR_W  last word address, latched on an accepted start.
- cpuBusy  in  1  CPU owns the memory port this cycle; controller must not read.
- memAddress  out  32  word address to memory, zero-extended from ADDR_W.
- memReadEn  out  1  controller read strobe.
- memData  in  32  combinational memory read data.
- txStart  out  1  one-cycle byte-send pulse to the UART.
- txData  out  8  byte to send; valid while txStart=1.
- txBusy  in  1  UART busy; asserts within 2 cycles of txStart and drops when the byte is finished.
- busy  out  1  controller not in IDLE.
- done  out  1  one-cycle pulse when the last byte of lastAddr has completed.
- wordCount  out  ADDR_W+1  words fully transmitted in the current or last dump.

Behaviour:
- Reset (async): state=IDLE, all outputs 0, internal address/byte index/shift register 0, wordCount=0.
- States and transitions:
  - IDLE: start=1 -> latch firstAddr/lastAddr into curAddr/endAddr, clear wordCount, go to READ (busy=1 on the next cycle).
  - READ: drive memAddress=curAddr every cycle.
    - cpuBusy=1: memReadEn=0, stay in READ.
    - cpuBusy=0: memReadEn=1 for this one cycle, capture memData into the shift register at the clock edge, byteIdx=0, go to SEND.
  - SEND: if txBusy=0, txStart=1 for one cycle with txData = the current byte, then go to ACK_HI; otherwise wait in SEND.
  - ACK_HI: wait for txBusy=1.
    - If txBusy is still 0 after 2 cycles, treat the byte as already finished and go to ACK_LO; this supports fast transmitters.
  - ACK_LO: wait for txBusy=0.
    - byteIdx<3: byteIdx++, go to SEND.
    - Else wordCount++ and:
      - curAddr==endAddr: go to IDLE and pulse done in the same edge's following cycle (done=1 for exactly one cycle, busy=0 in that cycle).
      - Otherwise curAddr=curAddr+1 modulo 2^ADDR_W (wrap 1023->0), go to READ.
- Byte order per word: LSB_FIRST=0 -> [31:24],[23:16],[15:8],[7:0]; LSB_FIRST=1 -> the reverse.
- Range: lastAddr<firstAddr is legal and wraps through 1023 to 0. firstAddr==lastAddr dumps exactly one word. Total words = ((lastAddr-firstAddr) mod 2^ADDR_W)+1.
- Outside READ, memReadEn=0 and memAddress holds curAddr.
- txStart is never asserted while txBusy=1. At most one txStart per byte.
- start while busy=1: ignored, no effect on latched range.
- abort: any non-IDLE state -> IDLE on the next edge.
  - txStart forced 0 in the abort cycle; no done pulse.
  - wordCount keeps the count of completed words.
  - A byte already handed to the UART is not recalled.
- abort and start in the same cycle in IDLE: start wins (abort has no meaning in IDLE).
- Reset mid-dump: immediate return to IDLE with all outputs 0.
- memData is ignored in every cycle except the READ cycle with memReadEn=1.

Test Plan:
1. mem[5]=0xA1B2C3D4, firstAddr=lastAddr=5, start, UART model busy 10 cycles/byte -> txData sequence A1,B2,C3,D4; 4 txStart pulses; done pulses once; wordCount=1; busy=0.
2. LSB_FIRST=1, same data -> bytes D4,C3,B2,A1.
3. firstAddr=1022, lastAddr=1, mem[1022..1023,0..1] distinct values -> memAddress sequence 1022,1023,0,1; 16 bytes in order; wordCount=4.
4. Hold cpuBusy=1 for 7 cycles after entering READ -> memReadEn stays 0 for those 7 cycles, asserts on cycle 8; data captured is the value at that cycle; no byte is lost.
5. Assert abort after the 2nd byte of a 3-word dump -> IDLE next cycle; no further txStart; no done; wordCount=0. A subsequent start runs a full dump normally.
6. Assert rst mid-SEND, and pulse start while busy -> outputs 0 immediately on rst; start while busy does not alter the range or the byte stream (checked against the expected byte list).
